// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: front end for the 3-to-8 LED decoder.
// Raw board switches and buttons are synchronised and debounced. In manual
// mode the debounced 3-bit code goes straight to the decoder. In auto mode a
// prescaled up/down scan counter walks the lit LED one position per step.
// All outputs are registered. They are computed from the next state, so the
// decoder sees a new mode on the same edge that the FSM moves to it.
module decoder_scan_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int DEB_W       = 20,
    parameter int STEP_CYCLES = 50000000,
    parameter int STEP_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_in,
    input  logic       en_in,
    input  logic       btn_mode,
    output logic [2:0] enable,
    output logic [2:0] switch,
    output logic       auto_mode,
    output logic       step_tick
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2
    } state_t;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    // Bit map of the raw inputs: [2:0] code switches, [3] enable, [4] mode button.
    logic [4:0]       raw;
    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       db;
    logic [DEB_W-1:0] deb_cnt [5];

    logic [2:0] sw_db;
    logic       en_db;
    logic       btn_db;
    logic       btn_prev;
    logic       toggle;
    logic       auto_mode_next;

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] presc;
    logic [STEP_W-1:0] presc_next;
    logic [2:0]        scan;
    logic [2:0]        scan_next;
    logic              tick_next;
    logic [2:0]        enable_next;
    logic [2:0]        switch_next;

    assign raw    = {btn_mode, en_in, sw_in};
    assign sw_db  = db[2:0];
    assign en_db  = db[3];
    assign btn_db = db[4];

    // A rising edge of the debounced button flips the mode in every state.
    assign toggle         = btn_db & ~btn_prev;
    assign auto_mode_next = auto_mode ^ toggle;

    // Two-flop synchronisers, then one debounce counter per input.
    // A new level is accepted only after DEB_CYCLES cycles of disagreement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] != db[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        db[i]      <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Next-state logic. Losing the enable wins over any mode change.
    always_comb begin
        state_next = state;
        if (!en_db) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = auto_mode_next ? AUTO : MANUAL;
                MANUAL:  if (toggle && auto_mode_next) state_next = AUTO;
                AUTO:    if (toggle && !auto_mode_next) state_next = MANUAL;
                default: state_next = IDLE;
            endcase
        end
    end

    // Scan datapath and output values. A step happens only when AUTO is both
    // the current and the next state. This stops a wrap that coincides with
    // a transition from moving the code.
    always_comb begin
        presc_next  = presc;
        scan_next   = scan;
        tick_next   = 1'b0;
        enable_next = 3'b000;
        switch_next = 3'b000;
        if (state_next == AUTO) begin
            if (state != AUTO) begin
                scan_next  = sw_db;
                presc_next = '0;
            end else if (presc == STEP_LAST) begin
                presc_next = '0;
                tick_next  = 1'b1;
                scan_next  = sw_db[0] ? (scan - 3'd1) : (scan + 3'd1);
            end else begin
                presc_next = presc + 1'b1;
            end
        end else begin
            presc_next = '0;
        end
        case (state_next)
            MANUAL: begin
                enable_next = 3'b100;
                switch_next = sw_db;
            end
            AUTO: begin
                enable_next = 3'b100;
                switch_next = scan_next;
            end
            default: begin
                enable_next = 3'b000;
                switch_next = 3'b000;
            end
        endcase
    end

    // State, mode, scan and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            btn_prev  <= 1'b0;
            auto_mode <= 1'b0;
            presc     <= '0;
            scan      <= 3'b000;
            enable    <= 3'b000;
            switch    <= 3'b000;
            step_tick <= 1'b0;
        end else begin
            state     <= state_next;
            btn_prev  <= btn_db;
            auto_mode <= auto_mode_next;
            presc     <= presc_next;
            scan      <= scan_next;
            enable    <= enable_next;
            switch    <= switch_next;
            step_tick <= tick_next;
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: directed test of decoder_scan_ctrl.
// Parameters are DEB_CYCLES=4 and STEP_CYCLES=8. Inputs change 1 ns after a
// rising edge. Outputs are checked 1 ns after the edge being counted.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] sw_in;
    logic       en_in;
    logic       btn_mode;
    logic [2:0] enable;
    logic [2:0] switch;
    logic       auto_mode;
    logic       step_tick;

    int n_total;
    int n_bad;
    int tick_seen;

    logic [2:0] exp_q[$];
    logic [2:0] exp_sw;

    decoder_scan_ctrl #(
        .DEB_CYCLES (4),
        .DEB_W      (3),
        .STEP_CYCLES(8),
        .STEP_W     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .en_in    (en_in),
        .btn_mode (btn_mode),
        .enable   (enable),
        .switch   (switch),
        .auto_mode(auto_mode),
        .step_tick(step_tick)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Same as step, counting step_tick pulses observed after each edge.
    task automatic step_count(input int n);
        tick_seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (step_tick) tick_seen++;
        end
    endtask

    // Scoreboard check
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b0;
        sw_in    = 3'b011;
        en_in    = 1'b0;
        btn_mode = 1'b0;

        // Reset held for three edges
        step(3);
        chk("rst_enable", 8'(enable), 8'h0);
        chk("rst_switch", 8'(switch), 8'h0);
        chk("rst_auto", 8'(auto_mode), 8'h0);
        chk("rst_tick", 8'(step_tick), 8'h0);

        // Release reset and turn on the display with code 101. The change
        // must appear exactly 7 edges later.
        rst   = 1'b1;
        en_in = 1'b1;
        sw_in = 3'b101;
        step(6);
        chk("lat_early_enable", 8'(enable), 8'h0);
        step(1);
        chk("lat_enable", 8'(enable), 8'h4);
        chk("lat_switch", 8'(switch), 8'h5);

        // A 3-cycle glitch on sw_in[1] is rejected
        sw_in = 3'b111;
        step(3);
        sw_in = 3'b101;
        step(10);
        chk("glitch_reject", 8'(switch), 8'h5);

        // The same change held long enough is accepted
        sw_in = 3'b111;
        step(8);
        chk("glitch_accept", 8'(switch), 8'h7);

        // Auto up-scan from 110
        sw_in = 3'b110;
        step(10);
        chk("man_110", 8'(switch), 8'h6);
        btn_mode = 1'b1;
        step(6);
        chk("up_auto_pre", 8'(auto_mode), 8'h0);
        step(1);
        chk("up_auto", 8'(auto_mode), 8'h1);
        chk("up_load", 8'(switch), 8'h6);
        chk("up_load_tick", 8'(step_tick), 8'h0);
        btn_mode = 1'b0;
        exp_q.push_back(3'b111);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_sw = 3'b110;
        while (exp_q.size() > 0) begin
            step(7);
            chk("up_hold_sw", 8'(switch), 8'(exp_sw));
            chk("up_hold_tick", 8'(step_tick), 8'h0);
            step(1);
            exp_sw = exp_q.pop_front();
            chk("up_step_sw", 8'(switch), 8'(exp_sw));
            chk("up_step_tick", 8'(step_tick), 8'h1);
        end
        step(1);
        chk("up_tick_width", 8'(step_tick), 8'h0);

        // Back to manual, select 001 (direction down), enter auto again
        btn_mode = 1'b1;
        step(7);
        chk("to_manual", 8'(auto_mode), 8'h0);
        btn_mode = 1'b0;
        sw_in    = 3'b001;
        step(10);
        chk("man_001", 8'(switch), 8'h1);
        btn_mode = 1'b1;
        step(7);
        chk("dn_auto", 8'(auto_mode), 8'h1);
        chk("dn_load", 8'(switch), 8'h1);
        btn_mode = 1'b0;
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b111);
        exp_q.push_back(3'b110);
        while (exp_q.size() > 0) begin
            step(8);
            exp_sw = exp_q.pop_front();
            chk("dn_step_sw", 8'(switch), 8'(exp_sw));
            chk("dn_step_tick", 8'(step_tick), 8'h1);
        end

        // Disable mid-scan
        step(3);
        en_in = 1'b0;
        step(6);
        chk("dis_early_enable", 8'(enable), 8'h4);
        step(1);
        chk("dis_enable", 8'(enable), 8'h0);
        chk("dis_switch", 8'(switch), 8'h0);
        chk("dis_tick", 8'(step_tick), 8'h0);
        step_count(12);
        chk("idle_no_tick", 8'(tick_seen), 8'h0);
        chk("idle_enable", 8'(enable), 8'h0);

        // Re-enable: auto re-entered with the code reloaded from the switches
        en_in = 1'b1;
        step(7);
        chk("reen_enable", 8'(enable), 8'h4);
        chk("reen_switch", 8'(switch), 8'h1);
        chk("reen_auto", 8'(auto_mode), 8'h1);
        step(7);
        chk("reen_hold_tick", 8'(step_tick), 8'h0);
        step(1);
        chk("reen_first_tick", 8'(step_tick), 8'h1);
        chk("reen_first_sw", 8'(switch), 8'h0);

        // Reset for one edge mid-scan
        step(3);
        rst = 1'b0;
        step(1);
        chk("mrst_enable", 8'(enable), 8'h0);
        chk("mrst_switch", 8'(switch), 8'h0);
        chk("mrst_auto", 8'(auto_mode), 8'h0);
        chk("mrst_tick", 8'(step_tick), 8'h0);
        rst = 1'b1;
        step_count(20);
        chk("mrst_no_tick", 8'(tick_seen), 8'h0);
        chk("mrst_manual_auto", 8'(auto_mode), 8'h0);
        chk("mrst_manual_enable", 8'(enable), 8'h4);
        chk("mrst_manual_switch", 8'(switch), 8'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
